// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle for alu_issue: master = the issuer, slave = its environment.
// out_taken exists only when ALU_ISSUE_BRANCH_EN is defined.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] in_pc;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wb_en;
  logic        out_zero;
  logic        out_err;
`ifdef ALU_ISSUE_BRANCH_EN
  logic        out_taken;
`endif

  modport master (
    input  in_valid, in_instr, in_rs_val, in_rt_val, in_pc,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_data1, alu_data2, alu_control,
    output out_valid, out_result, out_dest, out_wb_en, out_zero, out_err
`ifdef ALU_ISSUE_BRANCH_EN
    , output out_taken
`endif
  );

  modport slave (
    output in_valid, in_instr, in_rs_val, in_rt_val, in_pc,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_data1, alu_data2, alu_control,
    input  out_valid, out_result, out_dest, out_wb_en, out_zero, out_err
`ifdef ALU_ISSUE_BRANCH_EN
    , input out_taken
`endif
  );
endinterface

// File: rtl/alu_issue.sv
// Issue stage for the single-cycle MIPS ALU: decode, register operands, capture result, hand off.
// Optional feature macro: ALU_ISSUE_BRANCH_EN (beq/bne decode and out_taken).
module alu_issue (
  input logic        clk,
  input logic        rst,
  alu_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic        accept_s;
  logic [5:0]  opcode_s, funct_s;
  logic [31:0] imm_sext_s, imm_zext_s;
  logic [3:0]  dec_ctrl_s;
  logic [31:0] dec_d1_s, dec_d2_s;
  logic [4:0]  dec_dest_s;
  logic        dec_wb_s, dec_wb_final_s, dec_err_s, dec_beq_s, dec_bne_s;
  logic        unused_shamt_s;

  logic        in_ready_r, out_valid_r;
  logic [31:0] alu_data1_r, alu_data2_r, out_result_r;
  logic [3:0]  alu_control_r;
  logic [4:0]  dest_r, out_dest_r;
  logic        wb_r, err_r, beq_r, bne_r;
  logic        out_wb_en_r, out_zero_r, out_err_r, out_taken_r;

  assign opcode_s       = bus.in_instr[31:26];
  assign funct_s        = bus.in_instr[5:0];
  assign imm_sext_s     = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign imm_zext_s     = {16'h0000, bus.in_instr[15:0]};
  assign unused_shamt_s = ^bus.in_instr[10:6];
  assign dec_wb_final_s = dec_wb_s & (dec_dest_s != 5'd0);
  assign accept_s       = (state_r == IDLE) && bus.in_valid && in_ready_r;

  // Instruction decode; anything unrecognised leaves the safe all-zero operand/control set.
  always_comb begin
    dec_ctrl_s = 4'b0000;
    dec_d1_s   = 32'h0000_0000;
    dec_d2_s   = 32'h0000_0000;
    dec_dest_s = 5'd0;
    dec_wb_s   = 1'b0;
    dec_err_s  = 1'b0;
    dec_beq_s  = 1'b0;
    dec_bne_s  = 1'b0;
    case (opcode_s)
      6'b000000: begin
        dec_d1_s   = bus.in_rs_val;
        dec_d2_s   = bus.in_rt_val;
        dec_dest_s = bus.in_instr[15:11];
        dec_wb_s   = 1'b1;
        case (funct_s)
          6'b100000, 6'b100001: dec_ctrl_s = 4'b0010;
          6'b100010, 6'b100011: dec_ctrl_s = 4'b0110;
          6'b100100:            dec_ctrl_s = 4'b0000;
          6'b100101:            dec_ctrl_s = 4'b0001;
          6'b100111:            dec_ctrl_s = 4'b1100;
          6'b101010:            dec_ctrl_s = 4'b0111;
          default: begin
            dec_d1_s   = 32'h0000_0000;
            dec_d2_s   = 32'h0000_0000;
            dec_dest_s = 5'd0;
            dec_wb_s   = 1'b0;
            dec_err_s  = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b100011: begin
        dec_d1_s   = bus.in_rs_val;
        dec_dest_s = bus.in_instr[20:16];
        dec_wb_s   = 1'b1;
        case (opcode_s)
          6'b001010: begin dec_ctrl_s = 4'b0111; dec_d2_s = imm_sext_s; end
          6'b001100: begin dec_ctrl_s = 4'b0000; dec_d2_s = imm_zext_s; end
          6'b001101: begin dec_ctrl_s = 4'b0001; dec_d2_s = imm_zext_s; end
          default:   begin dec_ctrl_s = 4'b0010; dec_d2_s = imm_sext_s; end
        endcase
      end
      6'b101011: begin
        dec_ctrl_s = 4'b0010;
        dec_d1_s   = bus.in_rs_val;
        dec_d2_s   = imm_sext_s;
      end
      6'b000011: begin
        dec_ctrl_s = 4'b0011;
        dec_d1_s   = bus.in_pc;
        dec_dest_s = 5'd31;
        dec_wb_s   = 1'b1;
      end
`ifdef ALU_ISSUE_BRANCH_EN
      6'b000100, 6'b000101: begin
        dec_ctrl_s = 4'b0110;
        dec_d1_s   = bus.in_rs_val;
        dec_d2_s   = bus.in_rt_val;
        dec_beq_s  = (opcode_s == 6'b000100);
        dec_bne_s  = (opcode_s == 6'b000101);
      end
`endif
      default: dec_err_s = 1'b1;
    endcase
  end

  // Next-state logic for the accept / evaluate / hand-off sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ISSUE;
        else          state_s = IDLE;
      end
      ISSUE: state_s = DONE;
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath registers: operands load on accept, writeback packet loads in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      alu_data1_r   <= 32'h0000_0000;
      alu_data2_r   <= 32'h0000_0000;
      alu_control_r <= 4'b0000;
      dest_r        <= 5'd0;
      wb_r          <= 1'b0;
      err_r         <= 1'b0;
      beq_r         <= 1'b0;
      bne_r         <= 1'b0;
      out_result_r  <= 32'h0000_0000;
      out_dest_r    <= 5'd0;
      out_wb_en_r   <= 1'b0;
      out_zero_r    <= 1'b0;
      out_err_r     <= 1'b0;
      out_taken_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      if (accept_s) begin
        alu_data1_r   <= dec_d1_s;
        alu_data2_r   <= dec_d2_s;
        alu_control_r <= dec_ctrl_s;
        dest_r        <= dec_dest_s;
        wb_r          <= dec_wb_final_s;
        err_r         <= dec_err_s;
        beq_r         <= dec_beq_s;
        bne_r         <= dec_bne_s;
      end
      if (state_r == ISSUE) begin
        out_result_r <= err_r ? 32'h0000_0000 : bus.alu_result;
        out_dest_r   <= dest_r;
        out_wb_en_r  <= wb_r;
        out_zero_r   <= bus.alu_zero;
        out_err_r    <= err_r;
        out_taken_r  <= (beq_r & bus.alu_zero) | (bne_r & ~bus.alu_zero);
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.alu_data1   = alu_data1_r;
  assign bus.alu_data2   = alu_data2_r;
  assign bus.alu_control = alu_control_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_result  = out_result_r;
  assign bus.out_dest    = out_dest_r;
  assign bus.out_wb_en   = out_wb_en_r;
  assign bus.out_zero    = out_zero_r;
  assign bus.out_err     = out_err_r;
`ifdef ALU_ISSUE_BRANCH_EN
  assign bus.out_taken   = out_taken_r;
`else
  logic unused_taken_s;
  assign unused_taken_s = out_taken_r;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU attached to its operand ports.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();
  alu_issue dut (.clk(clk), .rst(rst), .bus(bus.master));

  // Behavioural ALU; SLT is unsigned, 0011 passes operand 1 through (link value).
  always_comb begin
    case (bus.alu_control)
      4'b0010: bus.alu_result = bus.alu_data1 + bus.alu_data2;
      4'b0110: bus.alu_result = bus.alu_data1 - bus.alu_data2;
      4'b0000: bus.alu_result = bus.alu_data1 & bus.alu_data2;
      4'b0001: bus.alu_result = bus.alu_data1 | bus.alu_data2;
      4'b1100: bus.alu_result = ~(bus.alu_data1 | bus.alu_data2);
      4'b0111: bus.alu_result = (bus.alu_data1 < bus.alu_data2) ? 32'd1 : 32'd0;
      4'b0011: bus.alu_result = bus.alu_data1;
      default: bus.alu_result = 32'h0000_0000;
    endcase
    bus.alu_zero = (bus.alu_result == 32'h0000_0000);
  end

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, result;
    logic [4:0]  dest;
    logic        wb, zero, err, taken;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic [4:0] d, input logic w,
                              input logic z, input logic e, input logic t);
    exp_t x;
    x.ctrl = c; x.d1 = a; x.d2 = b; x.result = r; x.dest = d;
    x.wb = w; x.zero = z; x.err = e; x.taken = t;
    return x;
  endfunction

  task automatic do_txn(input string name, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc, input exp_t e, input int hold);
    exp_t cur;
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin @(negedge clk); waited++; end
    total++;
    if (!bus.in_ready) begin
      $display("FAIL %s in_ready timeout got 0 want 1", name);
      return;
    end
    passed++;
    bus.in_instr = instr; bus.in_rs_val = rs; bus.in_rt_val = rt; bus.in_pc = pc;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cur = sb[0];
    total++; if (bus.alu_control !== cur.ctrl) $display("FAIL %s ctrl got %h want %h", name, bus.alu_control, cur.ctrl); else passed++;
    total++; if (bus.alu_data1 !== cur.d1) $display("FAIL %s data1 got %h want %h", name, bus.alu_data1, cur.d1); else passed++;
    total++; if (bus.alu_data2 !== cur.d2) $display("FAIL %s data2 got %h want %h", name, bus.alu_data2, cur.d2); else passed++;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL %s T+1 valid/ready got %b%b want 00", name, bus.out_valid, bus.in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL %s out_valid got %b want 1", name, bus.out_valid); else passed++;
    cur = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      total++; if (bus.out_result !== cur.result) $display("FAIL %s result got %h want %h", name, bus.out_result, cur.result); else passed++;
      total++; if (bus.out_dest !== cur.dest || bus.out_wb_en !== cur.wb) $display("FAIL %s dest/wb got %0d/%b want %0d/%b", name, bus.out_dest, bus.out_wb_en, cur.dest, cur.wb); else passed++;
      total++; if (bus.out_zero !== cur.zero || bus.out_err !== cur.err) $display("FAIL %s zero/err got %b/%b want %b/%b", name, bus.out_zero, bus.out_err, cur.zero, cur.err); else passed++;
`ifdef ALU_ISSUE_BRANCH_EN
      total++; if (bus.out_taken !== cur.taken) $display("FAIL %s taken got %b want %b", name, bus.out_taken, cur.taken); else passed++;
`endif
      if (h < hold) begin
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL %s hold valid/ready got %b%b want 10", name, bus.out_valid, bus.in_ready); else passed++;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL %s release valid/ready got %b%b want 01", name, bus.out_valid, bus.in_ready); else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL reset ready/valid got %b%b want 00", bus.in_ready, bus.out_valid); else passed++;
    total++; if (bus.alu_data1 !== 32'h0 || bus.alu_data2 !== 32'h0 || bus.alu_control !== 4'h0) $display("FAIL reset alu got %h %h %h want 0", bus.alu_data1, bus.alu_data2, bus.alu_control); else passed++;
    total++; if (bus.out_result !== 32'h0 || bus.out_dest !== 5'd0 || bus.out_wb_en !== 1'b0 || bus.out_zero !== 1'b0 || bus.out_err !== 1'b0) $display("FAIL reset out got %h %0d %b%b%b want 0", bus.out_result, bus.out_dest, bus.out_wb_en, bus.out_zero, bus.out_err); else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release in_ready got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_rtype();
    do_txn("add", {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd5, 32'd7, 32'h0, mk(4'b0010, 32'd5, 32'd7, 32'd12, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_txn("slt", {6'b000000, 5'd1, 5'd2, 5'd5, 5'd0, 6'b101010}, 32'd3, 32'hFFFF_FFFF, 32'h0, mk(4'b0111, 32'd3, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_txn("nor", {6'b000000, 5'd1, 5'd2, 5'd7, 5'd0, 6'b100111}, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0, mk(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_txn("addu_r0", {6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001}, 32'd5, 32'd7, 32'h0, mk(4'b0010, 32'd5, 32'd7, 32'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
  endtask

  task automatic test_itype();
    do_txn("addi", {6'b001000, 5'd1, 5'd4, 16'hFFFF}, 32'd1, 32'd0, 32'h0, mk(4'b0010, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0), 0);
    do_txn("andi", {6'b001100, 5'd1, 5'd4, 16'hFFFF}, 32'd1, 32'd0, 32'h0, mk(4'b0000, 32'd1, 32'h0000_FFFF, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_txn("sw", {6'b101011, 5'd2, 5'd6, 16'h0010}, 32'd100, 32'd55, 32'h0, mk(4'b0010, 32'd100, 32'h10, 32'd116, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
    do_txn("jal", {6'b000011, 26'h000_0040}, 32'd9, 32'd9, 32'h400, mk(4'b0011, 32'h400, 32'h0, 32'h400, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0), 0);
  endtask

  task automatic test_illegal();
    do_txn("illegal", {6'b111111, 26'h123_4567}, 32'd8, 32'd9, 32'h0, mk(4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), 0);
  endtask

  task automatic test_branch();
`ifdef ALU_ISSUE_BRANCH_EN
    do_txn("beq", {6'b000100, 5'd1, 5'd2, 16'h0004}, 32'd9, 32'd9, 32'h0, mk(4'b0110, 32'd9, 32'd9, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), 0);
    do_txn("bne", {6'b000101, 5'd1, 5'd2, 16'h0004}, 32'd9, 32'd9, 32'h0, mk(4'b0110, 32'd9, 32'd9, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 0);
`else
    do_txn("beq_illegal", {6'b000100, 5'd1, 5'd2, 16'h0004}, 32'd9, 32'd9, 32'h0, mk(4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), 0);
`endif
  endtask

  task automatic test_backpressure();
    do_txn("backpressure", {6'b000000, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100010}, 32'd20, 32'd6, 32'h0, mk(4'b0110, 32'd20, 32'd6, 32'd14, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), 4);
    repeat (2) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL ignored_in_valid out_valid got %b want 0", bus.out_valid); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_ori", {6'b001101, 5'd1, 5'd8, 16'h8000}, 32'h0000_0001, 32'd0, 32'h0, mk(4'b0001, 32'h1, 32'h0000_8000, 32'h0000_8001, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_txn("b2b_lw", {6'b100011, 5'd1, 5'd10, 16'hFFFC}, 32'h0000_0100, 32'd0, 32'h0, mk(4'b0010, 32'h100, 32'hFFFF_FFFC, 32'h0000_00FC, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0), 0);
  endtask

  task automatic test_reset_in_issue();
    @(negedge clk);
    bus.in_instr = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
    bus.in_rs_val = 32'd5; bus.in_rt_val = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.alu_control !== 4'h0 || bus.alu_data1 !== 32'h0) $display("FAIL rst_issue state got %b%b %h %h want 00 0 0", bus.out_valid, bus.in_ready, bus.alu_control, bus.alu_data1); else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL rst_issue after got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); else passed++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_instr = 32'h0; bus.in_rs_val = 32'h0; bus.in_rt_val = 32'h0; bus.in_pc = 32'h0;
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_reset_in_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
